// File: rtl/sdf_fft_stage.sv
// sdf_fft_stage: radix-2 single-path delay-feedback DIF FFT stage with stall and inverse mode
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid, in_r, in_i  : complex input sample, accepted when in_valid=1
//   inv                   : inverse mode (conjugate twiddles), latched at frame start
//   out_valid, out_r, out_i : registered complex output sample
//   Build option SDF_SCALE_EN: halve sum and difference (round half up) in every stage
module sdf_fft_stage #(
  parameter int DW      = 12,
  parameter int N       = 8,
  parameter int TW_FRAC = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  input  logic                 inv,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i
);
  localparam int D  = N / 2;
  localparam int CW = $clog2(N);
  localparam int KW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * DW + 2;
  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [DW:0]   ext_t;
  typedef logic signed [PW-1:0] prd_t;
  localparam prd_t EMAX = prd_t'((2 ** DW) - 1);
  localparam prd_t EMIN = -prd_t'(2 ** DW);

  function automatic smp_t sat_out(input ext_t v);
    return (v[DW] == v[DW-1]) ? v[DW-1:0] : {v[DW], {(DW-1){~v[DW]}}};
  endfunction

  function automatic ext_t sat_ext(input prd_t v);
    return (v > EMAX) ? {1'b0, {DW{1'b1}}} : (v < EMIN) ? {1'b1, {DW{1'b0}}} : v[DW:0];
  endfunction

`ifdef SDF_SCALE_EN
  typedef logic signed [DW+1:0] wid_t;
  function automatic ext_t half(input wid_t v);
    return ext_t'((v + wid_t'(1)) >>> 1);
  endfunction
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d, inv_q, inv_d, out_valid_q, out_valid_d;
  smp_t          out_r_q, out_r_d, out_i_q, out_i_d;
  ext_t          dl_r_q [D];
  ext_t          dl_i_q [D];
  ext_t          hr, hi, xr, xi, sr, si, dr, di, push_r, push_i;
  logic          phase_b;
  logic [KW-1:0] k;
  prd_t          wr, wi, pr, pi;
  smp_t          tw_r [D];
  smp_t          tw_i [D];

  // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded half away from zero
  for (genvar t = 0; t < D; t++) begin : g_tw
    localparam real C = (2.0 ** TW_FRAC) * $cos(2.0 * 3.141592653589793 * t / N);
    localparam real S = (2.0 ** TW_FRAC) * $sin(2.0 * 3.141592653589793 * t / N);
    assign tw_r[t] = smp_t'($rtoi(C < 0.0 ? C - 0.5 : C + 0.5));
    assign tw_i[t] = smp_t'(-$rtoi(S < 0.0 ? S - 0.5 : S + 0.5));
  end

  // In phase B the head is a raw sample of the same frame, so sum/difference fit DW+1 bits
  always_comb begin
    phase_b = cnt_q >= CW'(D);
    k = KW'(cnt_q - CW'(D));
    hr = dl_r_q[D-1];
    hi = dl_i_q[D-1];
    xr = ext_t'(in_r);
    xi = ext_t'(in_i);
`ifdef SDF_SCALE_EN
    sr = half(wid_t'(hr) + wid_t'(xr));
    si = half(wid_t'(hi) + wid_t'(xi));
    dr = half(wid_t'(hr) - wid_t'(xr));
    di = half(wid_t'(hi) - wid_t'(xi));
`else
    sr = hr + xr;
    si = hi + xi;
    dr = hr - xr;
    di = hi - xi;
`endif
    wr = prd_t'(tw_r[k]);
    wi = inv_q ? -prd_t'(tw_i[k]) : prd_t'(tw_i[k]);
    pr = (prd_t'(dr) * wr - prd_t'(di) * wi) >>> TW_FRAC;
    pi = (prd_t'(dr) * wi + prd_t'(di) * wr) >>> TW_FRAC;
    push_r = phase_b ? sat_ext(pr) : xr;
    push_i = phase_b ? sat_ext(pi) : xi;
    cnt_d = in_valid ? cnt_q + 1'b1 : cnt_q;
    primed_d = primed_q | (in_valid & (cnt_q == CW'(D - 1)));
    inv_d = (in_valid && cnt_q == '0) ? inv : inv_q;
    out_valid_d = in_valid & primed_q;
    out_r_d = in_valid ? sat_out(phase_b ? sr : hr) : out_r_q;
    out_i_d = in_valid ? sat_out(phase_b ? si : hi) : out_i_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      for (int j = 0; j < D; j++) begin
        dl_r_q[j] <= '0;
        dl_i_q[j] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      if (in_valid) begin
        dl_r_q[0] <= push_r;
        dl_i_q[0] <= push_i;
        for (int j = 1; j < D; j++) begin
          dl_r_q[j] <= dl_r_q[j-1];
          dl_i_q[j] <= dl_i_q[j-1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
endmodule
